instr_encoder: RTL
==================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have port clk_i, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_i, input, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have port start_i, input, 1 bit: loads base_addr_i and enters RUN.
REQ-004 SHALL have port stop_i, input, 1 bit: requests return to IDLE.
REQ-005 SHALL have port base_addr_i, input, 32 bits: byte address of the first emitted word.
REQ-006 SHALL have port req_valid_i, input, 1 bit: a request is present.
REQ-007 SHALL have port req_ready_o, output, 1 bit: a request is accepted this cycle.
REQ-008 SHALL have port req_kind_i, input, 4 bits: 0 RTYPE, 1 ADDI, 2 SLTI, 3 BEQ, 4 LUI, 5 ORI, 6 BNE, 7 LW, 8 SW, 9 J, 10 BGT, 11 BGEZ, 12 JAL, 13 JR; 14 and 15 are illegal.
REQ-009 SHALL have ports rs_i, rt_i and rd_i, input, 5 bits each: register fields.
REQ-010 SHALL have port funct_i, input, 6 bits: R-type function code.
REQ-011 SHALL have port imm_i, input, 26 bits: jump target; bits [15:0] are the I-type immediate.
REQ-012 SHALL have port instr_o, output, 32 bits: encoded instruction word.
REQ-013 SHALL have port addr_o, output, 32 bits: byte address of instr_o.
REQ-014 SHALL have port instr_valid_o, output, 1 bit: instr_o and addr_o are valid.
REQ-015 SHALL have port instr_ready_i, input, 1 bit: the consumer takes the word this cycle.
REQ-016 SHALL have port count_o, output, 16 bits: number of words emitted.
REQ-017 SHALL have port err_o, output, 1 bit: sticky flag for an illegal kind.
REQ-018 SHALL have port state_o, output, 2 bits: 00 IDLE, 01 RUN, 10 ERR.

Function
REQ-019 SHALL accept a request only when req_valid_i and req_ready_o are both 1.
REQ-020 SHALL drive req_ready_o = (state == RUN) && !stop_pend && (!instr_valid_o || instr_ready_i).
REQ-021 SHALL register an accepted request into instr_o and addr_o with 1-cycle latency, setting instr_valid_o.
REQ-022 SHALL hold instr_o, addr_o and instr_valid_o stable while instr_valid_o=1 and instr_ready_i=0.
REQ-023 SHALL encode R-type as {6'h00, rs, rt, rd, 5'b0, funct}.
REQ-024 SHALL encode JR as {6'h00, rs, 15'b0, 6'b001000}.
REQ-025 SHALL encode I-type as {op, rs, rt, imm[15:0]} with these opcodes: ADDI 001000, SLTI 001010, BEQ 000100, ORI 001101, BNE 000101, LW 100011, SW 101011, BGT 000111.
REQ-026 SHALL encode LUI with rs forced to 0 (op 001111).
REQ-027 SHALL encode BGEZ as {000001, rs, 5'b00001, imm[15:0]}.
REQ-028 SHALL encode J as {000010, imm[25:0]} and JAL as {000011, imm[25:0]}.
REQ-029 SHALL increment the internal address by 4 per accepted request, wrapping modulo 2^32.
REQ-030 SHALL increment count_o once per output handshake, saturating at 0xFFFF.
REQ-031 On an accepted illegal kind, SHALL emit no word, set err_o, and enter ERR, in which req_ready_o=0; an already pending output word still drains.
REQ-032 SHALL implement these state transitions, all else holding:
- IDLE + start_i -> RUN: address := base_addr_i, count_o := 0.
- ERR + start_i -> RUN: also clears err_o.
- RUN + start_i: reloads the address and clears count_o.
REQ-033 In RUN, stop_i SHALL set stop_pend; once instr_valid_o=0, or its handshake completes, the block SHALL go to IDLE.
REQ-034 When start_i and stop_i are both 1, start_i SHALL win.

Reset
REQ-035 Reset SHALL put the block in IDLE with instr_o=0, addr_o=0, instr_valid_o=0, count_o=0, err_o=0, stop_pend=0 and the internal address=0.
REQ-036 Asserting reset mid-handshake SHALL discard any pending word.

Structure
REQ-037 Package instr_enc_pkg SHALL hold the kind enum, all opcode constants, FUNCT_JR and the state encoding.
REQ-038 The combinational field packing SHALL be a sub-module instr_field_pack (kind, fields -> 32-bit word, illegal flag).

Verification
REQ-039 Test 1: reset, start_i with base 0x00400000, then ADDI rs=1 rt=2 imm=0x0005 -> instr_o=0x20220005, addr_o=0x00400000, count_o=1.
REQ-040 Test 2: JAL imm=0x0100000 then JR rs=31 -> 0x0C100000 at base, then 0x03E00008 at base+4.
REQ-041 Test 3: instr_ready_i held 0 for 3 cycles -> instr_o stable, req_ready_o=0, and no address advance.
REQ-042 Test 4: kind 14 -> err_o=1, state_o=ERR, no word emitted; then start_i -> err_o=0, state_o=RUN.
REQ-043 Test 5: base 0xFFFFFFFC with two BGEZ rs=3 imm=0xFFFE -> 0x0461FFFE at 0xFFFFFFFC, then at 0x00000000.
REQ-044 Test 6: stop_i while a word is stalled -> state_o stays RUN until its handshake, then IDLE; asserting rst_i mid-stall -> instr_valid_o=0 immediately.

Source files
------------

// File: rtl/instr_enc_pkg.sv
// Shared kind encoding, opcode/funct constants and controller state encoding
// for the instruction encoder.
package instr_enc_pkg;

   typedef enum logic [3:0] {
      K_RTYPE = 4'd0,
      K_ADDI  = 4'd1,
      K_SLTI  = 4'd2,
      K_BEQ   = 4'd3,
      K_LUI   = 4'd4,
      K_ORI   = 4'd5,
      K_BNE   = 4'd6,
      K_LW    = 4'd7,
      K_SW    = 4'd8,
      K_J     = 4'd9,
      K_BGT   = 4'd10,
      K_BGEZ  = 4'd11,
      K_JAL   = 4'd12,
      K_JR    = 4'd13
   } kind_e;

   localparam logic [5:0] OP_SPECIAL = 6'b000000;
   localparam logic [5:0] OP_REGIMM  = 6'b000001;
   localparam logic [5:0] OP_J       = 6'b000010;
   localparam logic [5:0] OP_JAL     = 6'b000011;
   localparam logic [5:0] OP_BEQ     = 6'b000100;
   localparam logic [5:0] OP_BNE     = 6'b000101;
   localparam logic [5:0] OP_BGT     = 6'b000111;
   localparam logic [5:0] OP_ADDI    = 6'b001000;
   localparam logic [5:0] OP_SLTI    = 6'b001010;
   localparam logic [5:0] OP_ORI     = 6'b001101;
   localparam logic [5:0] OP_LUI     = 6'b001111;
   localparam logic [5:0] OP_LW      = 6'b100011;
   localparam logic [5:0] OP_SW      = 6'b101011;

   localparam logic [5:0] FUNCT_JR   = 6'b001000;
   localparam logic [4:0] RT_BGEZ    = 5'b00001;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_ERR  = 2'b10
   } state_e;

endpackage

// File: rtl/instr_field_pack.sv
// Combinational packing of request fields into a 32-bit instruction word,
// flagging kinds that have no encoding.
module instr_field_pack
   import instr_enc_pkg::*;
(
   input  logic [3:0]  kind,
   input  logic [4:0]  rs,
   input  logic [4:0]  rt,
   input  logic [4:0]  rd,
   input  logic [5:0]  funct,
   input  logic [25:0] imm,
   output logic [31:0] word,
   output logic        illegal
);

   always_comb begin
      // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
      word    = '0;
      illegal = 1'b0;
      case (kind_e'(kind))
         K_RTYPE: word = {OP_SPECIAL, rs, rt, rd, 5'b0, funct};
         K_JR:    word = {OP_SPECIAL, rs, 15'b0, FUNCT_JR};
         K_ADDI:  word = {OP_ADDI, rs, rt, imm[15:0]};
         K_SLTI:  word = {OP_SLTI, rs, rt, imm[15:0]};
         K_BEQ:   word = {OP_BEQ,  rs, rt, imm[15:0]};
         K_ORI:   word = {OP_ORI,  rs, rt, imm[15:0]};
         K_BNE:   word = {OP_BNE,  rs, rt, imm[15:0]};
         K_LW:    word = {OP_LW,   rs, rt, imm[15:0]};
         K_SW:    word = {OP_SW,   rs, rt, imm[15:0]};
         K_BGT:   word = {OP_BGT,  rs, rt, imm[15:0]};
         K_LUI:   word = {OP_LUI, 5'b0, rt, imm[15:0]};
         K_BGEZ:  word = {OP_REGIMM, rs, RT_BGEZ, imm[15:0]};
         K_J:     word = {OP_J,   imm};
         K_JAL:   word = {OP_JAL, imm};
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/instr_encoder.sv
// Request-to-instruction-word encoder with a one-deep output register,
// address/count tracking and an IDLE/RUN/ERR controller.
module instr_encoder
   import instr_enc_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic        stop_i,
   input  logic [31:0] base_addr_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic [3:0]  req_kind_i,
   input  logic [4:0]  rs_i,
   input  logic [4:0]  rt_i,
   input  logic [4:0]  rd_i,
   input  logic [5:0]  funct_i,
   input  logic [25:0] imm_i,
   output logic [31:0] instr_o,
   output logic [31:0] addr_o,
   output logic        instr_valid_o,
   input  logic        instr_ready_i,
   output logic [15:0] count_o,
   output logic        err_o,
   output logic [1:0]  state_o
);

   state_e      state;
   logic        stop_pend;
   logic [31:0] addr;
   logic [31:0] word;
   logic        illegal;
   logic        accept;
   logic        out_hs;

   instr_field_pack u_pack (
      .kind    (req_kind_i),
      .rs      (rs_i),
      .rt      (rt_i),
      .rd      (rd_i),
      .funct   (funct_i),
      .imm     (imm_i),
      .word    (word),
      .illegal (illegal)
   );

   assign req_ready_o = (state == ST_RUN) && !stop_pend && (!instr_valid_o || instr_ready_i);
   assign accept      = req_valid_i && req_ready_o;
   assign out_hs      = instr_valid_o && instr_ready_i;
   assign state_o     = state;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state         <= ST_IDLE;
         stop_pend     <= 1'b0;
         addr          <= '0;
         instr_o       <= '0;
         addr_o        <= '0;
         instr_valid_o <= 1'b0;
         count_o       <= '0;
         err_o         <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments; later statements override earlier ones in the same cycle.
         if (out_hs) begin
            instr_valid_o <= 1'b0;
            if (count_o != 16'hFFFF) count_o <= count_o + 16'd1;
         end

         if (accept) begin
            if (illegal) begin
               err_o <= 1'b1;
               state <= ST_ERR;
            end else begin
               instr_o       <= word;
               addr_o        <= addr;
               instr_valid_o <= 1'b1;
               addr          <= addr + 32'd4;
            end
         end

         // start_i has priority over stop and reloads the stream
         if (start_i) begin
            state     <= ST_RUN;
            addr      <= base_addr_i;
            count_o   <= '0;
            err_o     <= 1'b0;
            stop_pend <= 1'b0;
         end else if (state == ST_RUN && (stop_i || stop_pend)) begin
            if (!accept && (!instr_valid_o || out_hs)) begin
               state     <= ST_IDLE;
               stop_pend <= 1'b0;
            end else begin
               stop_pend <= 1'b1;
            end
         end
      end
   end

endmodule
